fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit five-stage pipeline, together with the IF/ID pipeline register.
- Owns the PC and drives instruction-memory address/request.
- Captures the returned instruction into the decode-side register.
- Consumes stallF, stallD and InstBranch from the hazard unit, plus the branch target from decode; feeds instD/pcD to decode.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width
- INST_W, 16, instruction width
- RESET_PC, 16'h0000, PC value after reset
- PC_INC, 1, PC increment per fetched instruction (word-addressed)
- NOP_INST, 16'h0000, encoding inserted into IF/ID on bubble or flush

Ports:
- clk  in  1  pipeline clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- stallF  in  1  hold PC (from hazard unit)
- stallD  in  1  hold IF/ID register (from hazard unit)
- InstBranch  in  1  taken branch resolved in decode; redirect and flush
- branch_target  in  ADDR_W  redirect address, valid with InstBranch
- imem_rdata  in  INST_W  instruction from memory
- imem_rdy  in  1  imem_rdata valid for the current imem_addr this cycle
- imem_addr  out  ADDR_W  = pcF (combinational from PC register)
- imem_req  out  1  fetch request
- pcF  out  ADDR_W  current fetch PC
- instD  out  INST_W  IF/ID instruction
- pcD  out  ADDR_W  PC of instD
- pcPlusD  out  ADDR_W  pcD + PC_INC (link/next address)
- validD  out  1  instD is a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst_n=0): pcF=RESET_PC, instD=NOP_INST, pcD=RESET_PC, pcPlusD=RESET_PC+PC_INC, validD=0, imem_req=0.
- Reset release takes effect on the first clk edge with rst_n=1. imem_req is a registered flag set to 1 on that edge.
- Mid-operation reset returns every register to its reset value immediately, independent of clk.
- imem_req=1 whenever out of reset and stallF=0. Memory may hold imem_rdy low for any number of cycles; imem_addr is stable while waiting.
- Fetch accept condition: acc = imem_rdy & ~stallF & ~stallD & ~InstBranch.
- PC update priority per clk edge:
  - InstBranch: pcF <= branch_target. Overrides stallF; the hazard unit asserts both together.
  - else stallF: pcF holds.
  - else acc: pcF <= pcF + PC_INC, modulo 2^ADDR_W. Wrap from all-ones to 0 is silent.
  - else (waiting on memory, or stallD alone): pcF holds.
- IF/ID update priority per clk edge:
  - InstBranch: validD<=0, instD<=NOP_INST. pcD/pcPlusD hold. The wrong-path fetch is discarded.
  - else stallD: all IF/ID fields hold. validD keeps its value, so a held bubble stays a bubble.
  - else acc: instD<=imem_rdata, pcD<=pcF, pcPlusD<=pcF+PC_INC, validD<=1.
  - else: bubble, validD<=0, instD<=NOP_INST, pcD/pcPlusD hold.
- Fetch latency: one instruction per cycle when imem_rdy=1 continuously; instruction appears in instD one cycle after acceptance.
- Branch penalty: target instruction is presented to memory the cycle after InstBranch, and reaches instD no earlier than two cycles after InstBranch.
- imem_rdata sampled only on acc. imem_rdy during stall or redirect is ignored, and the same address is re-requested later.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs stall_cnt (16) and bubble_cnt (16), both reset to 0 asynchronously.
  - stall_cnt increments each cycle with stallF|stallD.
  - bubble_cnt increments each clk edge that writes validD<=0 (flush or memory wait).
  - Both saturate at 16'hFFFF.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then imem_rdy=1 constantly, imem_rdata=16'h1000+addr -> pcF 0,1,2,3 on successive cycles; instD 16'h1000,16'h1001 with validD=1 from the second edge; pcPlusD=pcD+1.
- Memory wait: hold imem_rdy=0 for 3 cycles at pcF=5 -> pcF stays 5, validD=0 and instD=NOP_INST for 3 cycles; rdy=1 -> instD=imem_rdata, pcD=5.
- Load-use stall: stallF=stallD=1 for 2 cycles with instD=16'hABCD, pcF=8 -> instD, pcD, pcF unchanged; release -> fetching resumes from 8.
- Branch: InstBranch=1, stallF=stallD=1, branch_target=16'h0040 at pcF=12 -> next cycle pcF=16'h0040, validD=0, instD=NOP_INST; then instD=imem_rdata[0x40], pcD=16'h0040.
- Wrap and reset: set pcF=16'hFFFF via branch, accept -> pcF=0. Then drop rst_n mid-cycle -> pcF=RESET_PC and validD=0 before the next clk edge.
- With FETCH_PERF_EN: 3 stall cycles and 2 bubbles -> stall_cnt=3, bubble_cnt=2. Forced saturation holds at 16'hFFFF.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction-fetch stage with PC register and IF/ID pipeline
//            register for the 16-bit five-stage pipeline. Drives the
//            instruction-memory request, captures the returned instruction
//            and handles stall, memory-wait and branch-redirect cases.
// Options  : FETCH_PERF_EN - adds saturating stall_cnt / bubble_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_INC   = 1,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              InstBranch,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_rdy,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] pcF,
  output logic [INST_W-1:0] instD,
  output logic [ADDR_W-1:0] pcD,
  output logic [ADDR_W-1:0] pcPlusD,
  output logic              validD
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  localparam logic [ADDR_W-1:0] c_PC_INC     = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] c_RESET_PLUS = RESET_PC + c_PC_INC;

  // Architectural state
  logic              req_q;
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [INST_W-1:0] inst_q,   inst_d;
  logic [ADDR_W-1:0] pcd_q,    pcd_d;
  logic [ADDR_W-1:0] pcplus_q, pcplus_d;
  logic              valid_q,  valid_d;

  logic              w_acc;
  logic              w_bubble;
  logic [ADDR_W-1:0] w_pc_next_seq;

  // A fetch is accepted only when a request is outstanding, memory has the
  // data, and neither a stall nor a redirect wants the slot.
  assign w_acc         = req_q & imem_rdy & ~stallF & ~stallD & ~InstBranch;
  assign w_pc_next_seq = pc_q + c_PC_INC;   // wraps silently modulo 2^ADDR_W

  // Edges that write a bubble into IF/ID: flush, or no accepted fetch while decode advances
  assign w_bubble = InstBranch | (~stallD & ~w_acc);

  // Next-state for the PC: redirect beats stall, stall beats sequential advance
  always_comb begin
    pc_d = pc_q;
    if (InstBranch) begin
      pc_d = branch_target;
    end else if (w_acc) begin
      pc_d = w_pc_next_seq;
    end
  end

  // Next-state for IF/ID: flush, hold, load or bubble
  always_comb begin
    inst_d   = inst_q;
    pcd_d    = pcd_q;
    pcplus_d = pcplus_q;
    valid_d  = valid_q;
    if (InstBranch) begin
      // Wrong-path fetch is discarded; PC fields keep their last values.
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (stallD) begin
      // Hold everything, including a held bubble.
    end else if (w_acc) begin
      inst_d   = imem_rdata;
      pcd_d    = pc_q;
      pcplus_d = w_pc_next_seq;
      valid_d  = 1'b1;
    end else begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end
  end

  // PC, request flag and IF/ID registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 1'b0;
      pc_q     <= RESET_PC;
      inst_q   <= NOP_INST;
      pcd_q    <= RESET_PC;
      pcplus_q <= c_RESET_PLUS;
      valid_q  <= 1'b0;
    end else begin
      req_q    <= 1'b1;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pcd_q    <= pcd_d;
      pcplus_q <= pcplus_d;
      valid_q  <= valid_d;
    end
  end

  assign pcF       = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = req_q & ~stallF;
  assign instD     = inst_q;
  assign pcD       = pcd_q;
  assign pcPlusD   = pcplus_q;
  assign validD    = valid_q;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] bubble_cnt_q;

  // Saturating counters of stall cycles and bubble-writing edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else begin
      if ((stallF | stallD) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'h0001;
      end
      if (w_bubble && (bubble_cnt_q != 16'hFFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 16'h0001;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire
